// File: rtl/axis_chk_pkg.sv
// Shared types and constants for the AXI-Stream counting-packet checker.
// Holds the checker FSM encoding and the err_flags bit positions.
package axis_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IN_PKT = 2'd1,
    RESYNC = 2'd2
  } chk_state_e;

  localparam int ERR_START        = 0;
  localparam int ERR_SEQ          = 1;
  localparam int ERR_EARLY_LAST   = 2;
  localparam int ERR_MISSING_LAST = 3;
  localparam int ERR_W            = 4;

endpackage

// File: rtl/axis_ready_gen.sv
// Free-running backpressure generator: tready drops for one cycle in every
// STALL_PERIOD cycles, independent of upstream valid.
module axis_ready_gen #(
  parameter int unsigned STALL_PERIOD = 2
) (
  input  logic clk,
  input  logic resetn,
  output logic tready_o
);

  if (STALL_PERIOD > 1) begin : g_stall
    localparam int PW = $clog2(STALL_PERIOD);
    localparam logic [PW-1:0] LAST_PHASE = PW'(STALL_PERIOD - 1);

    logic [PW-1:0] phase_q, phase_d;
    logic          ready_q;

    always_comb begin
      phase_d = (phase_q == LAST_PHASE) ? '0 : phase_q + PW'(1);
    end

    // Ready is registered from the next phase so it lines up with the phase it describes.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        phase_q <= '0;
        ready_q <= 1'b1;
      end else begin
        phase_q <= phase_d;
        ready_q <= (phase_d != LAST_PHASE);
      end
    end

    assign tready_o = ready_q;
  end else begin : g_always_ready
    assign tready_o = 1'b1;
  end

endmodule

// File: rtl/axis_packet_checker.sv
// AXI-Stream sink that checks each packet against the ramp START_VAL..END_VAL
// and reports per-packet status, packet sums, saturating counters and sticky errors.
module axis_packet_checker
  import axis_chk_pkg::*;
#(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned START_VAL    = 800,
  parameter int unsigned END_VAL      = 808,
  parameter int unsigned STALL_PERIOD = 2,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned SUM_W        = 24
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              s_tvalid,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tlast,
  output logic              s_tready,
  input  logic              clear_stats,
  output logic              pkt_done,
  output logic              pkt_ok,
  output logic [SUM_W-1:0]  pkt_sum,
  output logic [CNT_W-1:0]  good_count,
  output logic [CNT_W-1:0]  bad_count,
  output logic [3:0]        err_flags
);

  localparam logic [DATA_W-1:0] START_V = DATA_W'(START_VAL);
  localparam logic [DATA_W-1:0] END_V   = DATA_W'(END_VAL);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  chk_state_e        state_q, state_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic              pktDone_q, pktOk_q;
  logic [SUM_W-1:0]  pktSum_q;
  logic [CNT_W-1:0]  good_q, bad_q;
  logic [ERR_W-1:0]  err_q;

  logic              beat;
  logic [SUM_W-1:0]  dataExt;
  logic [ERR_W-1:0]  errNew;
  logic              doneNow, okNow, countGood, countBad;

  axis_ready_gen #(
    .STALL_PERIOD(STALL_PERIOD)
  ) u_ready_gen (
    .clk     (clk),
    .resetn  (resetn),
    .tready_o(s_tready)
  );

  assign beat    = s_tvalid && s_tready;
  assign dataExt = SUM_W'(s_tdata);

  // exp_q sits at START_VAL while idle, so the first beat uses the same checks as later ones.
  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    sum_d     = sum_q;
    errNew    = '0;
    doneNow   = 1'b0;
    okNow     = 1'b0;
    countGood = 1'b0;
    countBad  = 1'b0;

    if (beat) begin
      case (state_q)
        IDLE, IN_PKT: begin
          sum_d = (state_q == IDLE) ? dataExt : sum_q + dataExt;
          if (s_tdata != exp_q) begin
            if (state_q == IDLE) errNew[ERR_START] = 1'b1;
            else                 errNew[ERR_SEQ]   = 1'b1;
          end
          if (s_tlast && (exp_q != END_V))  errNew[ERR_EARLY_LAST]   = 1'b1;
          if (!s_tlast && (exp_q == END_V)) errNew[ERR_MISSING_LAST] = 1'b1;

          if (errNew != '0) begin
            countBad = 1'b1;
            exp_d    = START_V;
            if (s_tlast) begin
              doneNow = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = RESYNC;
            end
          end else if (s_tlast) begin
            doneNow   = 1'b1;
            okNow     = 1'b1;
            countGood = 1'b1;
            exp_d     = START_V;
            state_d   = IDLE;
          end else begin
            exp_d   = exp_q + DATA_W'(1);
            state_d = IN_PKT;
          end
        end
        RESYNC: begin
          sum_d = sum_q + dataExt;
          if (s_tlast) begin
            doneNow = 1'b1;
            state_d = IDLE;
          end
        end
        default: begin
          exp_d   = START_V;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      exp_q     <= START_V;
      sum_q     <= '0;
      pktDone_q <= 1'b0;
      pktOk_q   <= 1'b0;
      pktSum_q  <= '0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      sum_q     <= sum_d;
      pktDone_q <= doneNow;
      if (doneNow) begin
        pktOk_q  <= okNow;
        pktSum_q <= sum_d;
      end
    end
  end

  // Statistics: clear wins over any same-cycle increment or new error.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      good_q <= '0;
      bad_q  <= '0;
      err_q  <= '0;
    end else if (clear_stats) begin
      good_q <= '0;
      bad_q  <= '0;
      err_q  <= '0;
    end else begin
      if (countGood && (good_q != CNT_MAX)) good_q <= good_q + CNT_W'(1);
      if (countBad && (bad_q != CNT_MAX))   bad_q  <= bad_q + CNT_W'(1);
      err_q <= err_q | errNew;
    end
  end

  assign pkt_done   = pktDone_q;
  assign pkt_ok     = pktOk_q;
  assign pkt_sum    = pktSum_q;
  assign good_count = good_q;
  assign bad_count  = bad_q;
  assign err_flags  = err_q;

endmodule

// File: tb/tb_axis_packet_checker.sv
// Directed bench for axis_packet_checker: a default instance (STALL_PERIOD=2)
// and a second one with STALL_PERIOD=3, CNT_W=2 for backpressure and saturation.
module tb_axis_packet_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn[2];
  logic        tvalid[2];
  logic        tlast[2];
  logic        clear[2];
  logic [15:0] tdata[2];

  logic        readyA, doneA, okA;
  logic [23:0] sumA;
  logic [15:0] goodA, badA;
  logic [3:0]  errA;

  logic        readyB, doneB, okB;
  logic [23:0] sumB;
  logic [1:0]  goodB, badB;
  logic [3:0]  errB;

  axis_packet_checker dutA (
    .clk        (clk),
    .resetn     (resetn[0]),
    .s_tvalid   (tvalid[0]),
    .s_tdata    (tdata[0]),
    .s_tlast    (tlast[0]),
    .s_tready   (readyA),
    .clear_stats(clear[0]),
    .pkt_done   (doneA),
    .pkt_ok     (okA),
    .pkt_sum    (sumA),
    .good_count (goodA),
    .bad_count  (badA),
    .err_flags  (errA)
  );

  axis_packet_checker #(
    .STALL_PERIOD(3),
    .CNT_W       (2)
  ) dutB (
    .clk        (clk),
    .resetn     (resetn[1]),
    .s_tvalid   (tvalid[1]),
    .s_tdata    (tdata[1]),
    .s_tlast    (tlast[1]),
    .s_tready   (readyB),
    .clear_stats(clear[1]),
    .pkt_done   (doneB),
    .pkt_ok     (okB),
    .pkt_sum    (sumB),
    .good_count (goodB),
    .bad_count  (badB),
    .err_flags  (errB)
  );

  int compared   = 0;
  int mismatched = 0;

  int          doneCnt[2] = '{0, 0};
  logic        lastOk[2]  = '{1'b0, 1'b0};
  logic [23:0] lastSum[2] = '{24'd0, 24'd0};

  // Record every completion pulse so counts, status and sums can be checked later.
  always @(negedge clk) begin
    if (doneA) begin
      doneCnt[0]++;
      lastOk[0]  = okA;
      lastSum[0] = sumA;
    end
    if (doneB) begin
      doneCnt[1]++;
      lastOk[1]  = okB;
      lastSum[1] = sumB;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    compared++;
    if (got !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, expected, expected);
    end
  endtask

  function automatic logic readyOf(input int sel);
    return (sel == 0) ? readyA : readyB;
  endfunction

  // Called at a negedge; holds the beat until a ready edge takes it, returns at the next negedge.
  task automatic applyStimulus(input int sel, input logic [15:0] d, input logic l);
    int guard = 0;
    tvalid[sel] = 1'b1;
    tdata[sel]  = d;
    tlast[sel]  = l;
    while (!readyOf(sel) && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 10) checkOutput("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic sendRamp(input int sel, input int first, input int last, input logic withLast);
    for (int v = first; v <= last; v++) applyStimulus(sel, 16'(v), withLast && (v == last));
  endtask

  task automatic idle(input int sel, input int n);
    tvalid[sel] = 1'b0;
    tlast[sel]  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic clearStats(input int sel);
    clear[sel] = 1'b1;
    @(negedge clk);
    clear[sel] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected summary before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    for (int i = 0; i < 2; i++) begin
      resetn[i] = 1'b0;
      tvalid[i] = 1'b0;
      tlast[i]  = 1'b0;
      clear[i]  = 1'b0;
      tdata[i]  = 16'd0;
    end
    repeat (2) @(negedge clk);

    checkOutput("rst_tready", readyA, 1);
    checkOutput("rst_done", doneA, 0);
    checkOutput("rst_ok", okA, 0);
    checkOutput("rst_sum", sumA, 0);
    checkOutput("rst_good", goodA, 0);
    checkOutput("rst_bad", badA, 0);
    checkOutput("rst_err", errA, 0);
    checkOutput("rst_tready_b", readyB, 1);

    resetn[0] = 1'b1;
    resetn[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("readyA_seq%0d", i), readyA, (i % 2) == 0);
      checkOutput($sformatf("readyB_seq%0d", i), readyB, (i % 3) != 2);
      @(negedge clk);
    end

    // Two clean packets back to back.
    d0 = doneCnt[0];
    sendRamp(0, 800, 808, 1'b1);
    checkOutput("t1_done_pulse", doneA, 1);
    checkOutput("t1_ok", okA, 1);
    checkOutput("t1_sum", sumA, 7236);
    sendRamp(0, 800, 808, 1'b1);
    idle(0, 1);
    checkOutput("t1_done_low", doneA, 0);
    checkOutput("t1_sum_held", sumA, 7236);
    idle(0, 1);
    checkOutput("t1_done_cnt", doneCnt[0] - d0, 2);
    checkOutput("t1_last_ok", lastOk[0], 1);
    checkOutput("t1_good", goodA, 2);
    checkOutput("t1_bad", badA, 0);
    checkOutput("t1_err", errA, 0);

    // Bad first beat, then a clean packet.
    clearStats(0);
    checkOutput("t2_clear_good", goodA, 0);
    d0 = doneCnt[0];
    applyStimulus(0, 16'd0, 1'b0);
    sendRamp(0, 801, 808, 1'b1);
    idle(0, 2);
    checkOutput("t2_err", errA, 4'b0001);
    checkOutput("t2_bad", badA, 1);
    checkOutput("t2_done_cnt", doneCnt[0] - d0, 1);
    checkOutput("t2_ok", lastOk[0], 0);
    checkOutput("t2_sum", lastSum[0], 6436);
    sendRamp(0, 800, 808, 1'b1);
    idle(0, 2);
    checkOutput("t2_good", goodA, 1);
    checkOutput("t2_ok_clean", lastOk[0], 1);

    // Sequence gap, then early last.
    clearStats(0);
    d0 = doneCnt[0];
    sendRamp(0, 800, 801, 1'b0);
    sendRamp(0, 803, 808, 1'b1);
    checkOutput("t3_seq_ok", okA, 0);
    checkOutput("t3_seq_sum", sumA, 6434);
    sendRamp(0, 800, 805, 1'b1);
    idle(0, 2);
    checkOutput("t3_err", errA, 4'b0110);
    checkOutput("t3_bad", badA, 2);
    checkOutput("t3_done_cnt", doneCnt[0] - d0, 2);
    checkOutput("t3_early_ok", lastOk[0], 0);
    checkOutput("t3_early_sum", lastSum[0], 4815);
    checkOutput("t3_good", goodA, 0);

    // Missing last on the END_VAL beat, packet ends one beat later.
    clearStats(0);
    sendRamp(0, 800, 808, 1'b0);
    checkOutput("t4_err_at_808", errA, 4'b1000);
    checkOutput("t4_no_done", doneA, 0);
    checkOutput("t4_bad_at_808", badA, 1);
    applyStimulus(0, 16'd809, 1'b1);
    checkOutput("t4_done", doneA, 1);
    checkOutput("t4_ok", okA, 0);
    checkOutput("t4_sum", sumA, 8045);
    idle(0, 2);
    checkOutput("t4_bad", badA, 1);

    // Reset in the middle of a packet; the tail is judged as a new packet.
    clearStats(0);
    sendRamp(0, 800, 803, 1'b0);
    tvalid[0] = 1'b0;
    resetn[0] = 1'b0;
    #1;
    checkOutput("t6_rst_tready", readyA, 1);
    checkOutput("t6_rst_done", doneA, 0);
    checkOutput("t6_rst_sum", sumA, 0);
    checkOutput("t6_rst_err", errA, 0);
    @(negedge clk);
    @(negedge clk);
    resetn[0] = 1'b1;
    sendRamp(0, 804, 808, 1'b1);
    checkOutput("t6_done", doneA, 1);
    checkOutput("t6_ok", okA, 0);
    checkOutput("t6_sum", sumA, 4030);
    checkOutput("t6_err", errA, 4'b0001);
    checkOutput("t6_bad", badA, 1);
    idle(0, 1);

    // Period-3 backpressure: a junk beat offered while not ready must be ignored.
    begin
      int guard = 0;
      while (readyB && guard < 10) begin
        @(negedge clk);
        guard++;
      end
      checkOutput("t5_find_stall", readyB, 0);
    end
    tvalid[1] = 1'b1;
    tdata[1]  = 16'd0;
    tlast[1]  = 1'b0;
    @(negedge clk);
    d0 = doneCnt[1];
    sendRamp(1, 800, 808, 1'b1);
    idle(1, 2);
    checkOutput("t5_good1", goodB, 1);
    checkOutput("t5_err", errB, 0);
    checkOutput("t5_bad", badB, 0);
    checkOutput("t5_sum", lastSum[1], 7236);
    for (int p = 0; p < 4; p++) sendRamp(1, 800, 808, 1'b1);
    idle(1, 2);
    checkOutput("t5_done_cnt", doneCnt[1] - d0, 5);
    checkOutput("t5_good_sat", goodB, 3);

    sendRamp(1, 800, 807, 1'b0);
    clear[1] = 1'b1;
    applyStimulus(1, 16'd808, 1'b1);
    clear[1] = 1'b0;
    checkOutput("t5_clr_done", doneB, 1);
    checkOutput("t5_clr_ok", okB, 1);
    checkOutput("t5_clr_good", goodB, 0);
    idle(1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
